// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and default widths for cache line storage
// Purpose: line refill state encoding plus way-level default geometry.
// Contents: line_state_e {IDLE, FILL, DONE}; DEFAULT_DATA_W, DEFAULT_TAG_W, DEFAULT_WORDS.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } line_state_e;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_TAG_W  = 24;
  localparam int DEFAULT_WORDS  = 4;

endpackage

// File: rtl/cache_word_reg.sv
// rtl/cache_word_reg.sv - one storage word with per-byte write enables
// Purpose: DATA_W-bit register, each byte lane written when its enable is set.
// Ports:
//   clk_i    in   clock, rising edge
//   reset_i  in   asynchronous active-high reset, clears word to 0
//   be_i     in   DATA_W/8 byte write enables
//   wdata_i  in   DATA_W write data
//   q_o      out  DATA_W stored word
module cache_word_reg #(
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     q_o
);

  logic [DATA_W-1:0] word_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      word_q <= '0;
    end else begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (be_i[b]) begin
          word_q[b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign q_o = word_q;

endmodule

// File: rtl/cache_line_store.sv
// rtl/cache_line_store.sv - one cache line: word storage, tag, valid, dirty, burst refill
// Purpose: WORDS x DATA_W line with byte-enable CPU writes and an in-order refill engine.
// Ports:
//   clk, reset                    clock and asynchronous active-high reset
//   sel                           set-decoder select; gates every command
//   cpu_wr/cpu_be/cpu_idx/cpu_wdata  CPU byte-enable write
//   cpu_rdata                     registered read of word[cpu_idx], 1-cycle latency
//   fill_start/fill_tag           begin refill and latch tag
//   fill_valid/fill_data/fill_ready  refill word handshake
//   fill_done                     one-cycle pulse when refill completes
//   invalidate                    clear valid/dirty and abort refill
//   tag_out/valid_out/dirty_out/busy  line status
module cache_line_store
  import cache_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int WORDS  = DEFAULT_WORDS,
  parameter int TAG_W  = DEFAULT_TAG_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sel,
  input  logic                        cpu_wr,
  input  logic [DATA_W/8-1:0]         cpu_be,
  input  logic [$clog2(WORDS)-1:0]    cpu_idx,
  input  logic [DATA_W-1:0]           cpu_wdata,
  output logic [DATA_W-1:0]           cpu_rdata,
  input  logic                        fill_start,
  input  logic [TAG_W-1:0]            fill_tag,
  input  logic                        fill_valid,
  input  logic [DATA_W-1:0]           fill_data,
  output logic                        fill_ready,
  output logic                        fill_done,
  input  logic                        invalidate,
  output logic [TAG_W-1:0]            tag_out,
  output logic                        valid_out,
  output logic                        dirty_out,
  output logic                        busy
);

  localparam int IDX_W = $clog2(WORDS);
  localparam int BE_W  = DATA_W / 8;

  line_state_e          state_q;
  logic [IDX_W-1:0]     cnt_q;
  logic [TAG_W-1:0]     tag_q;
  logic                 valid_q;
  logic                 dirty_q;
  logic                 done_q;
  logic [DATA_W-1:0]    rdata_q;

  logic [DATA_W-1:0]    word_val [WORDS];

  logic                 inv_cmd;
  logic                 start_cmd;
  logic                 fill_acc;
  logic                 cpu_we;

  // Command arbitration: invalidate beats fill_start beats cpu_wr.
  always_comb begin
    inv_cmd   = sel & invalidate;
    start_cmd = sel & fill_start & (state_q == IDLE) & ~inv_cmd;
    fill_acc  = sel & fill_valid & (state_q == FILL) & ~inv_cmd;
    cpu_we    = sel & cpu_wr & (state_q == IDLE) & valid_q & ~fill_start & ~inv_cmd;
  end

  // Per-word write-enable mux: a refill word owns the whole word, a CPU write only its enabled bytes.
  for (genvar w = 0; w < WORDS; w++) begin : g_word
    logic [BE_W-1:0]   be_w;
    logic [DATA_W-1:0] wdata_w;

    always_comb begin
      be_w    = '0;
      wdata_w = cpu_wdata;
      if (fill_acc && (cnt_q == IDX_W'(w))) begin
        be_w    = '1;
        wdata_w = fill_data;
      end else if (cpu_we && (cpu_idx == IDX_W'(w))) begin
        be_w    = cpu_be;
      end
    end

    cache_word_reg #(
      .DATA_W (DATA_W)
    ) u_word (
      .clk_i   (clk),
      .reset_i (reset),
      .be_i    (be_w),
      .wdata_i (wdata_w),
      .q_o     (word_val[w])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
      dirty_q <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      // Reads sample storage before this edge's writes land, so read+write returns old data.
      if (sel) begin
        rdata_q <= word_val[cpu_idx];
      end
      if (inv_cmd) begin
        // Words already written and the tag are left as they are.
        valid_q <= 1'b0;
        dirty_q <= 1'b0;
        cnt_q   <= '0;
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_cmd) begin
              tag_q   <= fill_tag;
              valid_q <= 1'b0;
              dirty_q <= 1'b0;
              cnt_q   <= '0;
              state_q <= FILL;
            end else if (cpu_we) begin
              dirty_q <= 1'b1;
            end
          end
          FILL: begin
            if (fill_acc) begin
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q == IDX_W'(WORDS - 1)) begin
                state_q <= DONE;
              end
            end
          end
          DONE: begin
            valid_q <= 1'b1;
            dirty_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign cpu_rdata  = rdata_q;
  assign fill_ready = (state_q == FILL);
  assign fill_done  = done_q;
  assign tag_out    = tag_q;
  assign valid_out  = valid_q;
  assign dirty_out  = dirty_q;
  assign busy       = (state_q != IDLE);

endmodule
